darkriscv_mem_responder: RTL and testbench

Bus responder at the memory end of the darkriscv core bus. It serves instruction fetches and data load/store requests from the core out of a single internal word-organised RAM. It inserts a programmable number of wait states by driving HLT. It decodes DLEN and address bits into byte-lane writes and flags illegal or out-of-range accesses. The block sits between the core and the simulation/FPGA memory map, and replaces ad-hoc behavioural RAM in benches.

---
 rtl/darkriscv_mem_responder_pkg.sv | 24 ++
 rtl/darkriscv_mem_responder_if.sv | 25 ++
 rtl/darkriscv_mem_responder_be.sv | 42 ++++
 rtl/darkriscv_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_darkriscv_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/darkriscv_mem_responder_pkg.sv
// Shared definitions for the darkriscv memory responder: DLEN encodings,
// FSM state type and a small one-hot check used by the request decoder.
package darkriscv_mem_pkg;

  localparam logic [2:0] DLEN_BYTE = 3'b001;
  localparam logic [2:0] DLEN_HALF = 3'b010;
  localparam logic [2:0] DLEN_WORD = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // True when exactly one of the three size bits is set.
  function automatic logic is_onehot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/darkriscv_mem_responder_if.sv
// Core-side bus of the darkriscv memory responder. The core is the master,
// the responder is the slave.
interface darkriscv_mem_responder_if;
  logic [31:0] IADDR;
  logic [31:0] IDATA;
  logic        DAS;
  logic        DRD;
  logic        DWR;
  logic [2:0]  DLEN;
  logic [31:0] DADDR;
  logic [31:0] DATAO;
  logic [31:0] DATAI;
  logic        HLT;
  logic        ERR;

  modport master (
    output IADDR, DAS, DRD, DWR, DLEN, DADDR, DATAO,
    input  IDATA, DATAI, HLT, ERR
  );

  modport slave (
    input  IADDR, DAS, DRD, DWR, DLEN, DADDR, DATAO,
    output IDATA, DATAI, HLT, ERR
  );
endinterface

// File: rtl/darkriscv_mem_responder_be.sv
// Byte-lane decoder: turns the one-hot access size and the low address bits
// into a 4-bit lane mask plus a misalignment flag. Non one-hot sizes give an
// empty mask and no misalignment; those are rejected elsewhere as illegal.
module darkriscv_mem_be
  import darkriscv_mem_pkg::*;
(
  input  logic [2:0] dlen,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);

  // Decode lane mask and alignment for the requested access size.
  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (dlen)
      DLEN_BYTE: begin
        be = 4'b0001 << addr_lo;
      end
      DLEN_HALF: begin
        case (addr_lo)
          2'b00:   be = 4'b0011;
          2'b10:   be = 4'b1100;
          default: misaligned = 1'b1;
        endcase
      end
      DLEN_WORD: begin
        if (addr_lo == 2'b00) begin
          be = 4'b1111;
        end else begin
          misaligned = 1'b1;
        end
      end
      default: begin
        be         = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/darkriscv_mem_responder.sv
// Memory-side responder for the darkriscv core bus. One word-organised RAM
// serves instruction fetches (1-cycle latency, frozen while stalled) and data
// loads/stores with a programmable number of HLT wait states.
module darkriscv_mem_responder
  import darkriscv_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                      CLK,
  input logic                      RES,
  darkriscv_mem_responder_if.slave bus
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic        HAS_WAIT  = (WAIT_STATES != 0);
  // First BUSY count: the request cycle itself is already one HLT cycle.
  localparam logic [3:0]  WAIT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0]   ram [MEM_WORDS];

  mem_state_t    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   idata_q, idata_d;
  logic [31:0]   datai_q, datai_d;
  logic          err_q, err_d;

  logic [31:0]   d_off_s, i_off_s;
  logic [AW-1:0] d_idx_s, i_idx_s;
  logic          d_in_range_s, i_in_range_s;
  logic [3:0]    be_s;
  logic          misaligned_s;
  logic          legal_s, fault_s, commit_s, write_s, hlt_s;

  darkriscv_mem_be u_be (
    .dlen       (bus.DLEN),
    .addr_lo    (bus.DADDR[1:0]),
    .be         (be_s),
    .misaligned (misaligned_s)
  );

  // Address map: offsets from the base, range checks and word indices.
  always_comb begin
    d_off_s      = bus.DADDR - BASE_ADDR;
    i_off_s      = bus.IADDR - BASE_ADDR;
    d_in_range_s = (d_off_s < MEM_BYTES);
    i_in_range_s = (i_off_s < MEM_BYTES);
    d_idx_s      = d_off_s[AW+1:2];
    i_idx_s      = i_off_s[AW+1:2];
    legal_s      = bus.DAS && (bus.DRD ^ bus.DWR) && is_onehot3(bus.DLEN);
    fault_s      = misaligned_s || !d_in_range_s;
  end

  // State register: FSM, wait counter and registered outputs.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idata_q <= 32'h0000_0000;
      datai_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idata_q <= idata_d;
      datai_q <= datai_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: enter BUSY to count wait states, leave on commit or abandon.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (legal_s && HAS_WAIT) begin
          state_d = BUSY;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!legal_s) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: stall, commit strobe, error pulse and next output values.
  always_comb begin
    hlt_s    = 1'b0;
    commit_s = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        hlt_s    = legal_s && HAS_WAIT;
        commit_s = legal_s && !HAS_WAIT;
        err_d    = bus.DAS && !legal_s;
      end
      BUSY: begin
        hlt_s    = legal_s && (cnt_q != 4'd0);
        commit_s = legal_s && (cnt_q == 4'd0);
        err_d    = !legal_s;
      end
      default: begin
        hlt_s    = 1'b0;
        commit_s = 1'b0;
        err_d    = 1'b0;
      end
    endcase
    // Reset must drop the stall at once, even with a request still on the bus.
    hlt_s = hlt_s && RES;
    if (commit_s && fault_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
    write_s = commit_s && bus.DWR && !fault_s && RES;

    if (hlt_s) begin
      idata_d = idata_q;
    end else if (i_in_range_s) begin
      idata_d = ram[i_idx_s];
    end else begin
      idata_d = 32'h0000_0000;
    end

    if (commit_s && bus.DRD) begin
      datai_d = fault_s ? 32'h0000_0000 : ram[d_idx_s];
    end else begin
      datai_d = datai_q;
    end
  end

  // RAM write port: byte-lane writes, contents deliberately not reset.
  always_ff @(posedge CLK) begin
    if (write_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          ram[d_idx_s][8*b +: 8] <= bus.DATAO[8*b +: 8];
        end
      end
    end
  end

  assign bus.IDATA = idata_q;
  assign bus.DATAI = datai_q;
  assign bus.ERR   = err_q;
  assign bus.HLT   = hlt_s;

endmodule

// File: tb/tb_darkriscv_mem_responder.sv
// Self-checking bench for darkriscv_mem_responder: three instances with 0, 2
// and 3 wait states, a vector table, hand-written multi-cycle sequences and a
// randomized run against a byte-level memory model.
module tb_darkriscv_mem_responder;
  import darkriscv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        das, drd, dwr;
    logic [2:0]  dlen;
    logic [31:0] daddr, datao, iaddr;
  } req_t;

  req_t rq [3];

  darkriscv_mem_responder_if bus0 ();
  darkriscv_mem_responder_if bus2 ();
  darkriscv_mem_responder_if bus3 ();

  assign bus0.DAS = rq[0].das;  assign bus0.DRD = rq[0].drd;  assign bus0.DWR = rq[0].dwr;
  assign bus0.DLEN = rq[0].dlen; assign bus0.DADDR = rq[0].daddr;
  assign bus0.DATAO = rq[0].datao; assign bus0.IADDR = rq[0].iaddr;
  assign bus2.DAS = rq[1].das;  assign bus2.DRD = rq[1].drd;  assign bus2.DWR = rq[1].dwr;
  assign bus2.DLEN = rq[1].dlen; assign bus2.DADDR = rq[1].daddr;
  assign bus2.DATAO = rq[1].datao; assign bus2.IADDR = rq[1].iaddr;
  assign bus3.DAS = rq[2].das;  assign bus3.DRD = rq[2].drd;  assign bus3.DWR = rq[2].dwr;
  assign bus3.DLEN = rq[2].dlen; assign bus3.DADDR = rq[2].daddr;
  assign bus3.DATAO = rq[2].datao; assign bus3.IADDR = rq[2].iaddr;

  darkriscv_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0))
    u_ws0 (.CLK(clk), .RES(rst_n), .bus(bus0.slave));
  darkriscv_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0))
    u_ws2 (.CLK(clk), .RES(rst_n), .bus(bus2.slave));
  darkriscv_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0))
    u_ws3 (.CLK(clk), .RES(rst_n), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic hlt_of(input int k);
    case (k)
      0: return bus0.HLT;
      1: return bus2.HLT;
      default: return bus3.HLT;
    endcase
  endfunction

  function automatic logic [31:0] out_of(input int k, input int which);
    logic [31:0] v;
    case (k)
      0: v = (which == 0) ? bus0.IDATA : (which == 1) ? bus0.DATAI : 32'(bus0.ERR);
      1: v = (which == 0) ? bus2.IDATA : (which == 1) ? bus2.DATAI : 32'(bus2.ERR);
      default: v = (which == 0) ? bus3.IDATA : (which == 1) ? bus3.DATAI : 32'(bus3.ERR);
    endcase
    return v;
  endfunction

  task automatic idle_req(input int k);
    rq[k].das = 1'b0; rq[k].drd = 1'b0; rq[k].dwr = 1'b0;
  endtask

  // Issue one request, hold it until HLT drops, then release it after the
  // commit edge. Returns at negedge+1 with DATAI/ERR of that access visible.
  task automatic do_access(input int k, input logic wr, input logic [2:0] dlen,
                           input logic [31:0] addr, input logic [31:0] data, output int hcyc);
    int n;
    hcyc = 0;
    n = 0;
    @(negedge clk);
    rq[k].das = 1'b1; rq[k].drd = !wr; rq[k].dwr = wr;
    rq[k].dlen = dlen; rq[k].daddr = addr; rq[k].datao = data;
    #1;
    while (hlt_of(k) && n < 40) begin
      hcyc++; n++;
      @(negedge clk); #1;
    end
    if (n >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL hlt_timeout: dut %0d still stalled after %0d cycles, required release", k, n);
    end
    @(negedge clk);
    idle_req(k);
    #1;
  endtask

  typedef struct {
    logic        das, drd, dwr;
    logic [2:0]  dlen;
    logic [31:0] addr, data;
    logic        exp_err;
    logic        chk_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [16];

  // Behavioural model of the RAM (only the windows used below are meaningful).
  logic [31:0] mm [1024];

  initial begin
    int h;
    logic [31:0] exp_err, exp_datai, exp_idata, ia, a, d;
    logic [2:0] dl;
    logic have_prev;
    int r, size;
    logic legal, ok;

    for (int k = 0; k < 3; k++) begin
      rq[k] = '0;
    end

    // Reset state of all three instances.
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_idata%0d", k), out_of(k, 0), 32'h0);
      chk($sformatf("rst_datai%0d", k), out_of(k, 1), 32'h0);
      chk($sformatf("rst_err%0d", k), out_of(k, 2), 32'h0);
      chk($sformatf("rst_hlt%0d", k), 32'(hlt_of(k)), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on the zero-wait instance.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, DLEN_WORD, 32'h10, 32'h11223344, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b0, 1'b1, 32'h11223344};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, DLEN_BYTE, 32'h11, 32'h0000AB00, 1'b0, 1'b1, 32'h11223344};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b0, 1'b1, 32'h1122AB44};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, DLEN_HALF, 32'h12, 32'hBEEF0000, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b0, 1'b1, 32'hBEEFAB44};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, DLEN_HALF, 32'h13, 32'h77770000, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b0, 1'b1, 32'hBEEFAB44};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, DLEN_WORD, 32'h10, 32'h0,        1'b1, 1'b1, 32'hBEEFAB44};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h1000, 32'h0,      1'b1, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 3'b011,    32'h10, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, DLEN_BYTE, 32'h13, 32'h0,        1'b0, 1'b1, 32'hBEEFAB44};
    tbl[13] = '{1'b1, 1'b0, 1'b1, DLEN_WORD, 32'h12, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hBEEFAB44};
    tbl[14] = '{1'b1, 1'b1, 1'b0, DLEN_WORD, 32'h10, 32'h0,        1'b0, 1'b1, 32'hBEEFAB44};
    tbl[15] = '{1'b1, 1'b1, 1'b0, DLEN_HALF, 32'h12, 32'h0,        1'b0, 1'b1, 32'hBEEFAB44};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rq[0].das = tbl[i].das; rq[0].drd = tbl[i].drd; rq[0].dwr = tbl[i].dwr;
      rq[0].dlen = tbl[i].dlen; rq[0].daddr = tbl[i].addr; rq[0].datao = tbl[i].data;
      #1;
      chk($sformatf("vec%0d_hlt", i), 32'(bus0.HLT), 32'h0);
      @(negedge clk);
      idle_req(0);
      #1;
      chk($sformatf("vec%0d_err", i), 32'(bus0.ERR), 32'(tbl[i].exp_err));
      if (tbl[i].chk_d) chk($sformatf("vec%0d_datai", i), bus0.DATAI, tbl[i].exp_d);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_err_pulse", i), 32'(bus0.ERR), 32'h0);
    end

    // Fetch: out of range returns zero, in range returns the word.
    @(negedge clk); rq[0].iaddr = 32'h1000;
    @(negedge clk); #1; chk("fetch_oor", bus0.IDATA, 32'h0);
    rq[0].iaddr = 32'h10;
    @(negedge clk); #1; chk("fetch_10", bus0.IDATA, 32'hBEEFAB44);

    // Fetch and write of the same word in one cycle sees the old value.
    do_access(0, 1'b1, DLEN_WORD, 32'h20, 32'hA5A50001, h);
    @(negedge clk);
    rq[0].iaddr = 32'h20;
    rq[0].das = 1'b1; rq[0].dwr = 1'b1; rq[0].drd = 1'b0;
    rq[0].dlen = DLEN_WORD; rq[0].daddr = 32'h20; rq[0].datao = 32'h5A5A0002;
    @(negedge clk); idle_req(0); #1;
    chk("fetch_prewrite", bus0.IDATA, 32'hA5A50001);
    @(negedge clk); #1;
    chk("fetch_postwrite", bus0.IDATA, 32'h5A5A0002);
    rq[0].iaddr = 32'h0;

    // Randomized run against the model on the zero-wait instance.
    for (int w = 64; w < 80; w++) begin
      mm[w] = $urandom;
      do_access(0, 1'b1, DLEN_WORD, 32'(w * 4), mm[w], h);
    end
    do_access(0, 1'b0, DLEN_WORD, 32'h100, 32'h0, h);
    chk("rnd_sync", bus0.DATAI, mm[64]);
    exp_datai = mm[64];
    exp_err = 32'h0;
    exp_idata = 32'h0;
    have_prev = 1'b0;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk); #1;
      if (have_prev) begin
        chk("rnd_err", 32'(bus0.ERR), exp_err);
        chk("rnd_datai", bus0.DATAI, exp_datai);
        chk("rnd_idata", bus0.IDATA, exp_idata);
      end
      r  = $urandom_range(0, 15);
      a  = ($urandom_range(0, 15) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                        : 32'h100 + 32'($urandom_range(0, 63));
      ia = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                       : 32'h100 + 32'($urandom_range(0, 63));
      d  = $urandom;
      case ($urandom_range(0, 2))
        0: dl = DLEN_BYTE;
        1: dl = DLEN_HALF;
        default: dl = DLEN_WORD;
      endcase
      rq[0].das = (r != 15); rq[0].drd = (r <= 5) || (r == 12) || (r == 14);
      rq[0].dwr = (r >= 6 && r <= 12);
      if (r == 14) dl = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
      rq[0].dlen = dl; rq[0].daddr = a; rq[0].datao = d; rq[0].iaddr = ia;

      // Model: fetch sees memory before this cycle's store.
      exp_idata = (ia < 32'd4096) ? mm[ia >> 2] : 32'h0;
      legal = rq[0].das && (rq[0].drd != rq[0].dwr) && (dl == 3'd1 || dl == 3'd2 || dl == 3'd4);
      exp_err = 32'h0;
      if (rq[0].das && !legal) begin
        exp_err = 32'h1;
      end else if (legal) begin
        size = (dl == 3'd1) ? 1 : (dl == 3'd2) ? 2 : 4;
        ok = (a < 32'd4096) && ((a % size) == 0);
        if (!ok) begin
          exp_err = 32'h1;
          if (rq[0].drd) exp_datai = 32'h0;
        end else if (rq[0].drd) begin
          exp_datai = mm[a >> 2];
        end else begin
          for (int k = 0; k < size; k++) begin
            mm[a >> 2][(int'(a % 4) + k) * 8 +: 8] = d[(int'(a % 4) + k) * 8 +: 8];
          end
        end
      end
      #1;
      chk("rnd_hlt", 32'(bus0.HLT), 32'h0);
      have_prev = 1'b1;
    end
    @(negedge clk); idle_req(0); #1;
    chk("rnd_err_last", 32'(bus0.ERR), exp_err);
    chk("rnd_datai_last", bus0.DATAI, exp_datai);
    rq[0].iaddr = 32'h0;

    // Two wait states: HLT length, IDATA freeze, DATAI after HLT falls.
    do_access(1, 1'b1, DLEN_WORD, 32'h10, 32'h0BADCAFE, h);
    chk("ws2_wr_hlt_cycles", 32'(h), 32'd2);
    do_access(1, 1'b1, DLEN_WORD, 32'h14, 32'h12345678, h);
    rq[1].iaddr = 32'h10;
    repeat (2) @(negedge clk);
    #1; chk("ws2_idata_pre", bus2.IDATA, 32'h0BADCAFE);
    @(negedge clk);
    rq[1].das = 1'b1; rq[1].drd = 1'b1; rq[1].dwr = 1'b0;
    rq[1].dlen = DLEN_WORD; rq[1].daddr = 32'h10; rq[1].iaddr = 32'h14;
    #1; chk("ws2_hlt_c0", 32'(bus2.HLT), 32'h1);
    @(negedge clk); #1;
    chk("ws2_hlt_c1", 32'(bus2.HLT), 32'h1);
    chk("ws2_idata_frozen1", bus2.IDATA, 32'h0BADCAFE);
    @(negedge clk); #1;
    chk("ws2_hlt_c2", 32'(bus2.HLT), 32'h0);
    chk("ws2_idata_frozen2", bus2.IDATA, 32'h0BADCAFE);
    @(negedge clk); idle_req(1); #1;
    chk("ws2_datai", bus2.DATAI, 32'h0BADCAFE);
    chk("ws2_idata_resume", bus2.IDATA, 32'h12345678);
    chk("ws2_err_none", 32'(bus2.ERR), 32'h0);
    // Out-of-range read keeps the wait timing but flags an error.
    do_access(1, 1'b0, DLEN_WORD, 32'h1000, 32'h0, h);
    chk("ws2_oor_hlt_cycles", 32'(h), 32'd2);
    chk("ws2_oor_err", 32'(bus2.ERR), 32'h1);
    chk("ws2_oor_datai", bus2.DATAI, 32'h0);
    // DAS dropped while BUSY: abandoned with an error pulse.
    @(negedge clk);
    rq[1].das = 1'b1; rq[1].drd = 1'b0; rq[1].dwr = 1'b1;
    rq[1].dlen = DLEN_WORD; rq[1].daddr = 32'h10; rq[1].datao = 32'hDEADDEAD;
    @(negedge clk); idle_req(1);
    @(negedge clk); #1;
    chk("ws2_abandon_err", 32'(bus2.ERR), 32'h1);
    do_access(1, 1'b0, DLEN_WORD, 32'h10, 32'h0, h);
    chk("ws2_abandon_nowrite", bus2.DATAI, 32'h0BADCAFE);

    // Three wait states: reset during BUSY discards the pending write.
    do_access(2, 1'b1, DLEN_WORD, 32'h40, 32'hCAFEF00D, h);
    chk("ws3_wr_hlt_cycles", 32'(h), 32'd3);
    @(negedge clk);
    rq[2].das = 1'b1; rq[2].drd = 1'b0; rq[2].dwr = 1'b1;
    rq[2].dlen = DLEN_WORD; rq[2].daddr = 32'h40; rq[2].datao = 32'h12345678;
    #1; chk("ws3_hlt_req", 32'(bus3.HLT), 32'h1);
    @(negedge clk); #1;
    chk("ws3_hlt_busy", 32'(bus3.HLT), 32'h1);
    #1; rst_n = 1'b0;
    #1; chk("ws3_hlt_in_reset", 32'(bus3.HLT), 32'h0);
    idle_req(2);
    @(negedge clk); rst_n = 1'b1;
    do_access(2, 1'b0, DLEN_WORD, 32'h40, 32'h0, h);
    chk("ws3_rd_hlt_cycles", 32'(h), 32'd3);
    chk("ws3_old_value", bus3.DATAI, 32'hCAFEF00D);
    do_access(0, 1'b0, DLEN_WORD, 32'h10, 32'h0, h);
    chk("ram_retained", bus0.DATAI, 32'hBEEFAB44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
